// File: rtl/gate_exerciser.sv
// gate_exerciser: sweeps all four {a,b} vectors onto a 2-input gate,
// checks gate_y against the selected function, reports pass/err/fail_vec.
// Ports: clk, rst_n, start, func_sel[2:0], gate_y in; gate_a, gate_b,
// busy, done, pass, err_count[ERR_W-1:0], fail_vec[3:0], cfg_err out.
module gate_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func_sel,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PASSES - 1);

  state_t           state, state_n;
  logic [1:0]       v, v_n;
  logic [SW-1:0]    scnt, scnt_n;
  logic [PW-1:0]    pcnt, pcnt_n;
  logic [2:0]       func, func_n;
  logic [ERR_W-1:0] err_n;
  logic [3:0]       fv_n;
  logic             pass_n, cfg_n, done_n;
  logic             a_n, b_n;
  logic             exp_y;

  assign busy = (state != IDLE);

  always_comb begin
    exp_y = 1'b0;
    case (func)
      3'b000:  exp_y = gate_a | gate_b;
      3'b001:  exp_y = gate_a & gate_b;
      3'b010:  exp_y = gate_a ^ gate_b;
      3'b011:  exp_y = ~(gate_a | gate_b);
      3'b100:  exp_y = ~(gate_a & gate_b);
      3'b101:  exp_y = ~(gate_a ^ gate_b);
      default: exp_y = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    v_n     = v;
    scnt_n  = scnt;
    pcnt_n  = pcnt;
    func_n  = func;
    err_n   = err_count;
    fv_n    = fail_vec;
    pass_n  = pass;
    cfg_n   = cfg_err;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (func_sel < 3'd6) begin
            func_n  = func_sel;
            err_n   = '0;
            fv_n    = '0;
            pass_n  = 1'b0;
            cfg_n   = 1'b0;
            v_n     = '0;
            pcnt_n  = '0;
            scnt_n  = '0;
            state_n = APPLY;
          end else begin
            cfg_n  = 1'b1;
            pass_n = 1'b0;
            done_n = 1'b1;
          end
        end
      end
      APPLY: begin
        if (scnt == S_LAST) begin
          scnt_n  = '0;
          state_n = CHECK;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      CHECK: begin
        if (gate_y != exp_y) begin
          if (err_count != '1) err_n = err_count + 1'b1;
          fv_n[v] = 1'b1;
        end
        if (v != 2'd3) begin
          v_n     = v + 2'd1;
          state_n = APPLY;
        end else if (pcnt != P_LAST) begin
          v_n     = '0;
          pcnt_n  = pcnt + 1'b1;
          state_n = APPLY;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end
      end
      default: state_n = IDLE;
    endcase
    a_n = (state_n != IDLE) & v_n[1];
    b_n = (state_n != IDLE) & v_n[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      v         <= '0;
      scnt      <= '0;
      pcnt      <= '0;
      func      <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
      cfg_err   <= 1'b0;
      done      <= 1'b0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
    end else begin
      state     <= state_n;
      v         <= v_n;
      scnt      <= scnt_n;
      pcnt      <= pcnt_n;
      func      <= func_n;
      err_count <= err_n;
      fail_vec  <= fv_n;
      pass      <= pass_n;
      cfg_err   <= cfg_n;
      done      <= done_n;
      gate_a    <= a_n;
      gate_b    <= b_n;
    end
  end

endmodule
